nios_led_cpu_oci_dct_ctrl: RTL and testbench

Debug-trace packing controller for the Nios CPU on-chip instrumentation.
- Accepts 2-bit direct-control-transfer (DCT) trace atoms and shifts them into a 30-bit accumulation buffer of 15 atoms.
- Each full or flushed buffer is launched as a 36-bit trace frame into a single-entry output register with a valid/ready handshake toward trace memory.
- Exposes the live dct_buffer/dct_count to the OCI test-bench monitor.
- Atoms cannot stall the CPU, so atoms that cannot be stored are dropped and counted.

---
 rtl/nios_led_cpu_oci_dct_ctrl_if.sv | 18 +
 rtl/nios_led_cpu_oci_dct_ctrl.sv | 114 +++++++++++
 tb/tb_nios_led_cpu_oci_dct_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_led_cpu_oci_dct_ctrl_if.sv
// rtl/nios_led_cpu_oci_dct_ctrl_if.sv - trace frame valid/ready channel toward trace memory
interface nios_led_cpu_oci_dct_ctrl_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [35:0] frame_data;

  modport master (
    output frame_valid,
    output frame_data,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    output frame_ready
  );
endinterface

// File: rtl/nios_led_cpu_oci_dct_ctrl.sv
// rtl/nios_led_cpu_oci_dct_ctrl.sv - packs 2-bit DCT trace atoms into 36-bit frames with drop accounting
module nios_led_cpu_oci_dct_ctrl #(
  parameter int ATOMS  = 15,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trace_enable,
  input  logic                   atom_valid,
  input  logic [1:0]             atom,
  input  logic                   flush,
  input  logic                   test_ending,
  nios_led_cpu_oci_dct_ctrl_if.master frm,
  output logic [2*ATOMS-1:0]     dct_buffer,
  output logic [3:0]             dct_count,
  output logic [DROP_W-1:0]      drop_count,
  input  logic                   drop_clr,
  output logic                   idle
);

  localparam int         BUF_W    = 2 * ATOMS;
  localparam logic [3:0] CNT_FULL = 4'(ATOMS);

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              fv_q, fv_d;
  logic [35:0]       fd_q, fd_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              flush_pend_q, flush_pend_d;
  logic              ovf_q, ovf_d;

  logic              out_free;
  logic              full;
  logic              launch;
  logic              accept;
  logic              drop;
  logic [BUF_W-1:0]  base_buf;
  logic [3:0]        base_cnt;

  always_comb begin
    out_free = !fv_q || frm.frame_ready;
    full     = (cnt_q == CNT_FULL);
    launch   = out_free && (full || (flush_pend_q && (cnt_q != 4'd0)));
    accept   = atom_valid && trace_enable;
    // A full buffer only loses an atom when the output register cannot take it this cycle.
    drop     = accept && full && !launch;
    base_buf = launch ? '0 : buf_q;
    base_cnt = launch ? 4'd0 : cnt_q;

    fv_d         = fv_q;
    fd_d         = fd_q;
    ovf_d        = ovf_q;
    buf_d        = base_buf;
    cnt_d        = base_cnt;
    drop_d       = drop_q;
    flush_pend_d = flush_pend_q && !launch && (cnt_q != 4'd0);

    if (launch) begin
      fd_d  = {ovf_q, (cnt_q != CNT_FULL), cnt_q, buf_q};
      fv_d  = 1'b1;
      ovf_d = 1'b0;
    end else if (fv_q && frm.frame_ready) begin
      fv_d = 1'b0;
    end

    if (accept && !drop) begin
      buf_d = {base_buf[BUF_W-3:0], atom};
      cnt_d = base_cnt + 4'd1;
    end

    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end

    if (drop_clr) begin
      drop_d = '0;
    end

    if (flush || test_ending) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      fv_q         <= 1'b0;
      fd_q         <= '0;
      drop_q       <= '0;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      fv_q         <= fv_d;
      fd_q         <= fd_d;
      drop_q       <= drop_d;
      flush_pend_q <= flush_pend_d;
      ovf_q        <= ovf_d;
    end
  end

  assign frm.frame_valid = fv_q;
  assign frm.frame_data  = fd_q;
  assign dct_buffer      = buf_q;
  assign dct_count       = cnt_q;
  assign drop_count      = drop_q;
  assign idle            = (cnt_q == 4'd0) && !fv_q && !flush_pend_q;

endmodule

// File: tb/tb_nios_led_cpu_oci_dct_ctrl.sv
// tb/tb_nios_led_cpu_oci_dct_ctrl.sv - self-checking bench for the DCT trace packing controller
module tb_nios_led_cpu_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trace_enable;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        flush;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_count;
  logic        drop_clr;
  logic        idle;

  nios_led_cpu_oci_dct_ctrl_if frm_if ();

  nios_led_cpu_oci_dct_ctrl #(.ATOMS(15), .DROP_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trace_enable (trace_enable),
    .atom_valid   (atom_valid),
    .atom         (atom),
    .flush        (flush),
    .test_ending  (test_ending),
    .frm          (frm_if.master),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .drop_count   (drop_count),
    .drop_clr     (drop_clr),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] sb[$];

  typedef struct {
    int          n;
    logic [1:0]  a0;
    logic [1:0]  stp;
    bit          fl;
    bit          use_te;
    bit          exp_frame;
    logic [1:0]  typ;
    logic [29:0] bufv;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && frm_if.frame_valid === 1'b1 && frm_if.frame_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: got %0h expected none", frm_if.frame_data);
      end else begin
        check("frame_data", 64'(frm_if.frame_data), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    logic [1:0] a;
    logic [35:0] f1, f2, f3;

    tbl[0] = '{15, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 2'b00, 30'h1555_5555};
    tbl[1] = '{3,  2'd3, 2'd3, 1'b1, 1'b0, 1'b1, 2'b01, 30'h0000_0039};
    tbl[2] = '{0,  2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'b00, 30'h0000_0000};
    tbl[3] = '{4,  2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 2'b01, 30'h0000_001B};
    tbl[4] = '{1,  2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 2'b01, 30'h0000_0002};
    tbl[5] = '{8,  2'd3, 2'd0, 1'b1, 1'b1, 1'b1, 2'b01, 30'h0000_FFFF};
    tbl[6] = '{15, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2'b00, 30'h06C6_C6C6};

    reset_n = 1'b0; trace_enable = 1'b0; atom_valid = 1'b0; atom = 2'd0;
    flush = 1'b0; test_ending = 1'b0; drop_clr = 1'b0; frm_if.frame_ready = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    check("rst_dct_count", 64'(dct_count), 64'd0);
    check("rst_dct_buffer", 64'(dct_buffer), 64'd0);
    check("rst_frame_valid", 64'(frm_if.frame_valid), 64'd0);
    check("rst_frame_data", 64'(frm_if.frame_data), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);

    frm_if.frame_ready = 1'b1;
    trace_enable = 1'b1;
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].exp_frame) sb.push_back({tbl[v].typ, 4'(tbl[v].n), tbl[v].bufv});
      a = tbl[v].a0;
      for (int i = 0; i < tbl[v].n; i++) begin
        atom_valid = 1'b1;
        atom = a;
        step();
        a = a + tbl[v].stp;
      end
      atom_valid = 1'b0;
      check($sformatf("vec%0d_count", v), 64'(dct_count), 64'(tbl[v].n));
      check($sformatf("vec%0d_buffer", v), 64'(dct_buffer), 64'(tbl[v].bufv));
      if (tbl[v].fl) begin
        if (tbl[v].use_te) test_ending = 1'b1; else flush = 1'b1;
        step();
        flush = 1'b0;
        test_ending = 1'b0;
      end
      repeat (4) step();
      check($sformatf("vec%0d_idle", v), 64'(idle), 64'd1);
      check($sformatf("vec%0d_drained", v), 64'(sb.size()), 64'd0);
    end

    // Backpressure: first frame held, second buffer fills, two atoms dropped.
    f1 = {2'b00, 4'd15, 30'h2AAA_AAAA};
    f2 = {2'b10, 4'd15, 30'h3FFF_FFFF};
    f3 = {2'b01, 4'd1,  30'h0000_0001};
    sb.push_back(f1);
    sb.push_back(f2);
    frm_if.frame_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      atom_valid = 1'b1;
      atom = (i < 15) ? 2'd2 : ((i < 30) ? 2'd3 : 2'd1);
      step();
    end
    atom_valid = 1'b0;
    check("bp_drop_count", 64'(drop_count), 64'd2);
    check("bp_dct_count", 64'(dct_count), 64'd15);
    check("bp_frame_valid", 64'(frm_if.frame_valid), 64'd1);
    check("bp_frame_held", 64'(frm_if.frame_data), 64'(f1));
    repeat (3) step();
    check("bp_frame_stable", 64'(frm_if.frame_data), 64'(f1));

    // Pop, launch and atom accept on the same edge.
    frm_if.frame_ready = 1'b1;
    atom_valid = 1'b1;
    atom = 2'd1;
    step();
    atom_valid = 1'b0;
    check("poplaunch_count", 64'(dct_count), 64'd1);
    check("poplaunch_drop", 64'(drop_count), 64'd2);
    check("poplaunch_valid", 64'(frm_if.frame_valid), 64'd1);
    check("poplaunch_data", 64'(frm_if.frame_data), 64'(f2));
    sb.push_back(f3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
    check("poplaunch_idle", 64'(idle), 64'd1);
    check("poplaunch_drained", 64'(sb.size()), 64'd0);

    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    check("drop_clr", 64'(drop_count), 64'd0);

    trace_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      atom_valid = 1'b1;
      atom = 2'd3;
      step();
    end
    atom_valid = 1'b0;
    check("dis_count", 64'(dct_count), 64'd0);
    check("dis_drop", 64'(drop_count), 64'd0);
    check("dis_idle", 64'(idle), 64'd1);
    trace_enable = 1'b1;

    // Saturation of the dropped-atom counter; frames are never popped here.
    frm_if.frame_ready = 1'b0;
    for (int i = 0; i < 331; i++) begin
      atom_valid = 1'b1;
      atom = 2'd1;
      step();
    end
    check("sat_drop", 64'(drop_count), 64'd255);
    drop_clr = 1'b1;
    step();
    drop_clr = 1'b0;
    atom_valid = 1'b0;
    check("clr_priority", 64'(drop_count), 64'd0);

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 22; i++) begin
      atom_valid = 1'b1;
      atom = 2'd2;
      step();
    end
    atom_valid = 1'b0;
    check("pre_rst_count", 64'(dct_count), 64'd7);
    check("pre_rst_valid", 64'(frm_if.frame_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(frm_if.frame_valid), 64'd0);
    check("async_rst_data", 64'(frm_if.frame_data), 64'd0);
    check("async_rst_count", 64'(dct_count), 64'd0);
    check("async_rst_buffer", 64'(dct_buffer), 64'd0);
    check("async_rst_idle", 64'(idle), 64'd1);
    step();
    reset_n = 1'b1;
    frm_if.frame_ready = 1'b1;
    repeat (3) step();
    check("final_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
